// File: rtl/cond_flags_unit.sv
// cond_flags_unit
// Computes {N, Z, C, V} for flag-setting compare/test instructions in the
// execute stage. The flags are held for one stage in a pending register and
// then committed to the architectural flag register. The branch-condition
// logic sees the pending value when one exists, so a branch directly after a
// compare gets the new flags without waiting for the commit.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_in_valid, i_set_flags execute-stage valid, instruction writes flags
//   i_flag_op               00 SUB (cmp), 01 ADD (cmn), 10 AND (tst), 11 XOR (teq)
//   i_src_a, i_src_b        operands
//   i_stall, i_flush        freeze all state / drop pending update and current input
//   o_alu_flags             {N, Z, C, V} to the branch-condition logic
//   o_flags_busy            flag write accepted this cycle (visible after the edge)
//   o_commit_count          flag commits since reset, wraps at 2^16
module cond_flags_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic             i_set_flags,
    input  logic [1:0]       i_flag_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [3:0]       o_alu_flags,
    output logic             o_flags_busy,
    output logic [15:0]      o_commit_count
);

    localparam logic [1:0] OpSub = 2'b00;
    localparam logic [1:0] OpAdd = 2'b01;
    localparam logic [1:0] OpAnd = 2'b10;
    localparam logic [1:0] OpXor = 2'b11;

    logic [3:0]       r_arch_flags;
    logic [3:0]       r_pend_flags;
    logic             r_pend_valid;
    logic [15:0]      r_commit_count;

    logic             w_accept;
    logic             w_commit;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;
    logic [3:0]       w_new_flags;
    logic [3:0]       w_alu_flags;

    assign w_accept = i_in_valid & i_set_flags & ~i_stall & ~i_flush;
    assign w_commit = r_pend_valid & ~i_stall & ~i_flush;

    // Shared adder: SUB is a + ~b + 1, so the carry-out is the "no borrow" bit.
    assign w_is_sub = (i_flag_op == OpSub);
    assign w_b_op   = w_is_sub ? ~i_src_b : i_src_b;
    assign w_sum    = {1'b0, i_src_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};

    // Forwarded flags; logic ops keep C/V from this, not from the arch register.
    assign w_alu_flags = r_pend_valid ? r_pend_flags : r_arch_flags;

    always_comb begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_alu_flags[1];
        w_ovf    = w_alu_flags[0];
        unique case (i_flag_op)
            OpSub: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (i_src_a[WIDTH-1] != i_src_b[WIDTH-1]) &
                           (w_sum[WIDTH-1] != i_src_a[WIDTH-1]);
            end
            OpAdd: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (i_src_a[WIDTH-1] == i_src_b[WIDTH-1]) &
                           (w_sum[WIDTH-1] != i_src_a[WIDTH-1]);
            end
            OpAnd: begin
                w_result = i_src_a & i_src_b;
            end
            OpXor: begin
                w_result = i_src_a ^ i_src_b;
            end
            default: begin
                w_result = w_sum[WIDTH-1:0];
            end
        endcase
        w_new_flags = {w_result[WIDTH-1], (w_result == '0), w_carry, w_ovf};
    end

    // Pending stage: flush wins over stall, stall holds everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_flags <= 4'b0000;
            r_pend_valid <= 1'b0;
        end else if (i_flush) begin
            r_pend_valid <= 1'b0;
        end else if (!i_stall) begin
            if (w_accept) begin
                r_pend_flags <= w_new_flags;
                r_pend_valid <= 1'b1;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Commit stage: runs in the same cycle as a new accept, so compares
    // pipeline at one per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arch_flags   <= 4'b0000;
            r_commit_count <= 16'd0;
        end else if (w_commit) begin
            r_arch_flags   <= r_pend_flags;
            r_commit_count <= r_commit_count + 16'd1;
        end
    end

    assign o_alu_flags    = w_alu_flags;
    assign o_flags_busy   = w_accept;
    assign o_commit_count = r_commit_count;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit (WIDTH = 32). Inputs change 1 time unit
// after the rising edge; outputs are sampled there too, away from the edge.
module tb_cond_flags_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             set_flags;
    logic [1:0]       flag_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall;
    logic             flush;
    logic [3:0]       alu_flags;
    logic             flags_busy;
    logic [15:0]      commit_count;

    int n_checks;
    int n_pass;

    cond_flags_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .i_set_flags    (set_flags),
        .i_flag_op      (flag_op),
        .i_src_a        (src_a),
        .i_src_b        (src_b),
        .i_stall        (stall),
        .i_flush        (flush),
        .o_alu_flags    (alu_flags),
        .o_flags_busy   (flags_busy),
        .o_commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic s, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic st, input logic fl);
        in_valid  = v;
        set_flags = s;
        flag_op   = op;
        src_a     = a;
        src_b     = b;
        stall     = st;
        flush     = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        idle();

        // Reset state
        chk("reset_flags", {12'd0, alu_flags}, 16'h0000);
        chk("reset_busy", {15'd0, flags_busy}, 16'h0000);
        chk("reset_count", commit_count, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        // SUB 5 - 5 -> 0110
        drive(1'b1, 1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
        chk("sub55_busy", {15'd0, flags_busy}, 16'h0001);
        chk("sub55_old_flags", {12'd0, alu_flags}, 16'h0000);
        tick();
        idle();
        chk("sub55_fwd", {12'd0, alu_flags}, 16'h0006);
        chk("sub55_cnt0", commit_count, 16'd0);
        tick();
        chk("sub55_commit", {12'd0, alu_flags}, 16'h0006);
        chk("sub55_cnt1", commit_count, 16'd1);

        // SUB 0x7FFFFFFF - 0xFFFFFFFF -> 1001, then ADD 0xFFFFFFFF + 1 -> 0110
        drive(1'b1, 1'b1, 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        chk("sub_ovf", {12'd0, alu_flags}, 16'h0009);
        drive(1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        chk("b2b_busy", {15'd0, flags_busy}, 16'h0001);
        tick();
        idle();
        chk("add_carry", {12'd0, alu_flags}, 16'h0006);
        chk("b2b_cnt2", commit_count, 16'd2);
        tick();
        chk("b2b_cnt3", commit_count, 16'd3);

        // Flush discards pending SUB 3 - 5
        drive(1'b1, 1'b1, 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        tick();
        chk("sub35_fwd", {12'd0, alu_flags}, 16'h0008);
        drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
        tick();
        chk("flush_flags", {12'd0, alu_flags}, 16'h0006);
        chk("flush_cnt", commit_count, 16'd3);
        // Flush + stall + accept in one cycle: input dropped
        drive(1'b1, 1'b1, 2'b00, 32'd3, 32'd5, 1'b1, 1'b1);
        chk("flush_stall_busy", {15'd0, flags_busy}, 16'h0000);
        tick();
        idle();
        chk("flush_stall_flags", {12'd0, alu_flags}, 16'h0006);
        tick();
        chk("flush_stall_cnt", commit_count, 16'd3);

        // Stall holds the pending entry for three cycles
        drive(1'b1, 1'b1, 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b01, 32'd1, 32'd1, 1'b1, 1'b0);
            chk("stall_busy", {15'd0, flags_busy}, 16'h0000);
            tick();
            chk("stall_flags", {12'd0, alu_flags}, 16'h0008);
            chk("stall_cnt", commit_count, 16'd3);
        end
        idle();
        tick();
        chk("unstall_flags", {12'd0, alu_flags}, 16'h0008);
        chk("unstall_cnt", commit_count, 16'd4);

        // AND after 1001 keeps forwarded C/V -> 0101
        drive(1'b1, 1'b1, 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 2'b10, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0);
        tick();
        idle();
        chk("and_flags", {12'd0, alu_flags}, 16'h0005);
        tick();
        chk("and_commit", {12'd0, alu_flags}, 16'h0005);
        chk("and_cnt", commit_count, 16'd6);

        // XOR after 0110 -> 1010
        drive(1'b1, 1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 2'b11, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        chk("xor_flags", {12'd0, alu_flags}, 16'h000A);
        tick();
        chk("xor_cnt", commit_count, 16'd8);

        // Non-flag instruction leaves flags alone
        drive(1'b1, 1'b0, 2'b01, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("noflag_busy", {15'd0, flags_busy}, 16'h0000);
        tick();
        idle();
        chk("noflag_flags", {12'd0, alu_flags}, 16'h000A);
        chk("noflag_cnt", commit_count, 16'd8);

        // Asynchronous reset mid-cycle with a pending entry
        drive(1'b1, 1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
        tick();
        idle();
        chk("pre_rst_flags", {12'd0, alu_flags}, 16'h0006);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {12'd0, alu_flags}, 16'h0000);
        chk("async_rst_cnt", commit_count, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Counter wrap: 65536 back-to-back compares, then one idle edge
        drive(1'b1, 1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
        for (int k = 0; k < 65536; k++) begin
            @(posedge clk);
        end
        #1;
        chk("wrap_ffff", commit_count, 16'hFFFF);
        idle();
        tick();
        chk("wrap_zero", commit_count, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
